// File: rtl/servo_pwm_driver.sv
// Four-channel 50 Hz hobby-servo PWM driver with frame-aligned angle latching and a settle/rdy handshake.
// Optional macro SLEW_LIMIT_EN: each channel ramps its commanded angle by SLEW_DEG degrees per frame.
module servo_pwm_driver #(
  parameter int FRAME_CYCLES        = 1000000,
  parameter int MIN_PULSE           = 25000,
  parameter int CYCLES_PER_DEG      = 556,
  parameter int MAX_ANGLE           = 180,
  parameter int SETTLE_FRAMES       = 25,
  parameter int SHORT_SETTLE_FRAMES = 1,
  parameter int RDY_WIDTH           = 4,
  parameter int SLEW_DEG            = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] angle1,
  input  logic [7:0] angle2,
  input  logic [7:0] angle3,
  input  logic [7:0] angle4,
  output logic [3:0] pwm,
  output logic       rdy,
  output logic       settling,
  output logic       frame_tick,
  output logic       angle_err
);

  localparam int CNT_W = $clog2(FRAME_CYCLES);
  localparam int W_W   = CNT_W + 1;
  localparam int SC_W  = $clog2(SETTLE_FRAMES + SHORT_SETTLE_FRAMES + 1) + 1;
  localparam int RC_W  = $clog2(RDY_WIDTH + 1);

  if (MIN_PULSE + MAX_ANGLE * CYCLES_PER_DEG >= FRAME_CYCLES) begin : g_bad_width
    $error("servo_pwm_driver: maximum pulse width does not fit inside one frame");
  end
  if (MAX_ANGLE > 255 || SLEW_DEG < 1 || RDY_WIDTH < 1) begin : g_bad_param
    $error("servo_pwm_driver: MAX_ANGLE, SLEW_DEG or RDY_WIDTH out of range");
  end

  typedef enum logic [1:0] {S_LATCH_WAIT, S_SETTLING, S_RDY} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_frame_cnt;
  logic [SC_W-1:0]  r_settle_cnt;
  logic [RC_W-1:0]  r_rdy_cnt;
  logic             r_first;
  logic [7:0]       r_lat [4];

  logic [7:0]       w_in [4];
  logic [7:0]       w_clamp [4];
  logic [7:0]       w_cmd [4];
  logic [W_W-1:0]   w_width [4];
  logic             w_fs;
  logic             w_latch;
  logic             w_changed;
  logic             w_over;
  logic             w_settled;

  assign w_in[0] = angle1;
  assign w_in[1] = angle2;
  assign w_in[2] = angle3;
  assign w_in[3] = angle4;

  assign w_fs    = (r_frame_cnt == '0);
  assign w_latch = enable && w_fs && (r_state == S_LATCH_WAIT);

  // r_lat doubles as the "previous" angle set: it only ever changes at a latch.
  always_comb begin
    w_changed = r_first;
    w_over    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w_clamp[i] = (w_in[i] > 8'(MAX_ANGLE)) ? 8'(MAX_ANGLE) : w_in[i];
      if (w_in[i] > 8'(MAX_ANGLE)) w_over = 1'b1;
      if (w_clamp[i] != r_lat[i])  w_changed = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_width[i] = W_W'(MIN_PULSE) + W_W'(w_cmd[i]) * W_W'(CYCLES_PER_DEG);
    end
  end

`ifdef SLEW_LIMIT_EN
  logic [7:0] r_cmd [4];
  logic [7:0] w_tgt [4];
  logic [7:0] w_cmd_nxt [4];

  // Step toward the target that will be latched this fs, so the first ramp step lands in the latch frame.
  always_comb begin
    w_settled = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w_tgt[i] = w_latch ? w_clamp[i] : r_lat[i];
      if (r_cmd[i] < w_tgt[i]) begin
        w_cmd_nxt[i] = (w_tgt[i] - r_cmd[i] > 8'(SLEW_DEG)) ? r_cmd[i] + 8'(SLEW_DEG) : w_tgt[i];
      end else begin
        w_cmd_nxt[i] = (r_cmd[i] - w_tgt[i] > 8'(SLEW_DEG)) ? r_cmd[i] - 8'(SLEW_DEG) : w_tgt[i];
      end
      if (r_cmd[i] != r_lat[i]) w_settled = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) r_cmd[i] <= '0;
    end else if (w_fs) begin
      for (int i = 0; i < 4; i++) r_cmd[i] <= w_cmd_nxt[i];
    end
  end

  assign w_cmd = r_cmd;
`else
  assign w_cmd     = r_lat;
  assign w_settled = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frame_cnt <= '0;
      frame_tick  <= 1'b0;
      pwm         <= '0;
    end else begin
      r_frame_cnt <= (r_frame_cnt == CNT_W'(FRAME_CYCLES - 1)) ? '0 : r_frame_cnt + CNT_W'(1);
      frame_tick  <= w_fs;
      for (int i = 0; i < 4; i++) begin
        pwm[i] <= enable && ({1'b0, r_frame_cnt} < w_width[i]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_LATCH_WAIT;
      r_settle_cnt <= '0;
      r_rdy_cnt    <= '0;
      r_first      <= 1'b1;
      rdy          <= 1'b0;
      settling     <= 1'b0;
      angle_err    <= 1'b0;
      for (int i = 0; i < 4; i++) r_lat[i] <= '0;
    end else if (!enable) begin
      r_state  <= S_LATCH_WAIT;
      r_first  <= 1'b1;
      rdy      <= 1'b0;
      settling <= 1'b0;
    end else begin
      case (r_state)
        S_LATCH_WAIT: begin
          if (w_fs) begin
            for (int i = 0; i < 4; i++) r_lat[i] <= w_clamp[i];
            if (w_over) angle_err <= 1'b1;
            r_settle_cnt <= w_changed ? SC_W'(SETTLE_FRAMES) : SC_W'(SHORT_SETTLE_FRAMES);
            r_first      <= 1'b0;
            settling     <= 1'b1;
            r_state      <= S_SETTLING;
          end
        end
        S_SETTLING: begin
          if (w_fs && w_settled) begin
            if (r_settle_cnt <= SC_W'(1)) begin
              settling  <= 1'b0;
              rdy       <= 1'b1;
              r_rdy_cnt <= RC_W'(RDY_WIDTH - 1);
              r_state   <= S_RDY;
            end else begin
              r_settle_cnt <= r_settle_cnt - SC_W'(1);
            end
          end
        end
        S_RDY: begin
          if (r_rdy_cnt == '0) begin
            rdy     <= 1'b0;
            r_state <= S_LATCH_WAIT;
          end else begin
            r_rdy_cnt <= r_rdy_cnt - RC_W'(1);
          end
        end
        default: r_state <= S_LATCH_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_servo_pwm_driver.sv
// Directed bench for servo_pwm_driver with a short 1000-cycle frame; widths and rdy timing measured per frame.
module tb_servo_pwm_driver;

  localparam int FC = 1000;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [7:0] angle1, angle2, angle3, angle4;
  logic [3:0] pwm;
  logic       rdy, settling, frame_tick, angle_err;

  always #5 clk = ~clk;

  servo_pwm_driver #(
    .FRAME_CYCLES(FC), .MIN_PULSE(25), .CYCLES_PER_DEG(5), .MAX_ANGLE(180),
    .SETTLE_FRAMES(3), .SHORT_SETTLE_FRAMES(1), .RDY_WIDTH(4), .SLEW_DEG(2)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .angle1(angle1), .angle2(angle2), .angle3(angle3), .angle4(angle4),
    .pwm(pwm), .rdy(rdy), .settling(settling), .frame_tick(frame_tick), .angle_err(angle_err)
  );

  typedef struct packed {
    logic [3:0][7:0]  a;
    logic             chg;
    logic             err;
    logic [3:0][15:0] w;
  } vec_t;

  vec_t vecs [7];

  int total = 0;
  int bad   = 0;

  // Per-frame monitor: w_hist[k] holds the pwm high count of the window starting at frame_tick number k.
  int   ft_cnt = 0;
  int   hi [4];
  int   w_hist [256][4];
  int   rdy_rises = 0, last_rise_tick = 0, rise_ft = 0;
  int   rdy_len = 0, last_rdy_len = 0, set_len = 0, last_set_len = 0;
  logic rdy_q = 1'b0, set_q = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      rdy_q   = 1'b0;
      set_q   = 1'b0;
      rdy_len = 0;
      set_len = 0;
    end else begin
      if (frame_tick) begin
        if (ft_cnt > 0 && ft_cnt < 256)
          for (int i = 0; i < 4; i++) w_hist[ft_cnt][i] = hi[i];
        ft_cnt++;
        for (int i = 0; i < 4; i++) hi[i] = int'(pwm[i]);
      end else begin
        for (int i = 0; i < 4; i++) hi[i] += int'(pwm[i]);
      end
      if (rdy) begin
        if (!rdy_q) begin
          rdy_rises++;
          last_rise_tick = ft_cnt;
          rise_ft        = int'(frame_tick);
          rdy_len        = 0;
        end
        rdy_len++;
      end else if (rdy_q) begin
        last_rdy_len = rdy_len;
      end
      if (settling) begin
        if (!set_q) set_len = 0;
        set_len++;
      end else if (set_q) begin
        last_set_len = set_len;
      end
      rdy_q = rdy;
      set_q = settling;
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic wait_rdy(output int tick, input string nm);
    int start;
    int n;
    start = rdy_rises;
    n = 0;
    while (rdy_rises == start && n < 12 * FC) begin
      @(posedge clk);
      n++;
    end
    if (rdy_rises == start) begin
      total++;
      bad++;
      $display("FAIL %s rdy timeout got=none exp=rise", nm);
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "rdy wait expired");
    end
    tick = last_rise_tick;
  endtask

  function automatic vec_t mk(input int a1, input int a2, input int a3, input int a4,
                              input bit chg, input bit err,
                              input int w1, input int w2, input int w3, input int w4);
    vec_t v;
    v.a[0] = 8'(a1); v.a[1] = 8'(a2); v.a[2] = 8'(a3); v.a[3] = 8'(a4);
    v.chg  = chg;
    v.err  = err;
    v.w[0] = 16'(w1); v.w[1] = 16'(w2); v.w[2] = 16'(w3); v.w[3] = 16'(w4);
    return v;
  endfunction

  initial begin
    int t, t2, base, n;
    bit prev_chg;

    vecs[0] = mk(0,   38, 0,   0,   1, 0, 25,  215, 25,  25);
    vecs[1] = mk(0,   38, 0,   0,   0, 0, 25,  215, 25,  25);
    vecs[2] = mk(90,  38, 0,   0,   1, 0, 475, 215, 25,  25);
    vecs[3] = mk(90,  38, 0,   200, 1, 1, 475, 215, 25,  925);
    vecs[4] = mk(90,  38, 0,   180, 0, 1, 475, 215, 25,  925);
    vecs[5] = mk(180, 0,  181, 255, 1, 1, 925, 25,  925, 925);
    vecs[6] = mk(0,   0,  0,   0,   1, 1, 25,  25,  25,  25);

    rst = 1'b0; enable = 1'b1;
    angle1 = 8'd0; angle2 = 8'd0; angle3 = 8'd0; angle4 = 8'd0;
    for (int i = 0; i < 4; i++) hi[i] = 0;
    repeat (3) @(negedge clk);
    chk("rst_pwm", int'(pwm), 0);
    chk("rst_rdy", int'(rdy), 0);
    chk("rst_settling", int'(settling), 0);
    chk("rst_frame_tick", int'(frame_tick), 0);
    chk("rst_angle_err", int'(angle_err), 0);
    rst = 1'b1;

    wait_rdy(t, "first");
    chk("first_rdy_tick", t, 4);
    chk("first_rdy_on_fs", rise_ft, 1);
    for (int i = 0; i < 4; i++) chk($sformatf("first_w%0d", i), w_hist[1][i], 25);
    prev_chg = 1'b1;

`ifdef SLEW_LIMIT_EN
    repeat (6) @(negedge clk);
    chk("first_rdy_len", last_rdy_len, 4);
    chk("first_settle_len", last_set_len, 3 * FC);
    angle1 = 8'd10;
    wait_rdy(t2, "slew");
    for (int f = 0; f < 5; f++) chk($sformatf("slew_w_f%0d", f), w_hist[t + 1 + f][0], 35 + 10 * f);
    chk("slew_w_other", w_hist[t + 1][1], 25);
    chk("slew_rdy_gap", t2 - (t + 1 + 4), 3);
    t = t2;
`else
    for (int k = 0; k < 7; k++) begin
      repeat (6) @(negedge clk);
      chk($sformatf("mv%0d_prev_rdy_len", k), last_rdy_len, 4);
      chk($sformatf("mv%0d_prev_settle_len", k), last_set_len, prev_chg ? 3 * FC : FC);
      angle1 = vecs[k].a[0]; angle2 = vecs[k].a[1];
      angle3 = vecs[k].a[2]; angle4 = vecs[k].a[3];
      wait_rdy(t2, $sformatf("mv%0d", k));
      chk($sformatf("mv%0d_rdy_gap", k), t2 - t, vecs[k].chg ? 4 : 2);
      for (int i = 0; i < 4; i++)
        chk($sformatf("mv%0d_w%0d", k, i), w_hist[t + 1][i], int'(vecs[k].w[i]));
      chk($sformatf("mv%0d_angle_err", k), int'(angle_err), int'(vecs[k].err));
      prev_chg = vecs[k].chg;
      t = t2;
    end
    repeat (6) @(negedge clk);
    chk("last_rdy_len", last_rdy_len, 4);
    chk("last_settle_len", last_set_len, 3 * FC);

    // Unchanged move latches at tick t+1; drop enable for 3 cycles early in that settling frame.
    n = 0;
    while (ft_cnt != t + 1 && n < 3 * FC) begin
      @(posedge clk);
      n++;
    end
    chk("en_sync_tick", ft_cnt, t + 1);
    @(negedge clk);
    chk("en_pre_pwm", int'(pwm), 15);
    @(negedge clk);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("en_off_pwm", int'(pwm), 0);
    chk("en_off_settling", int'(settling), 0);
    chk("en_off_rdy", int'(rdy), 0);
    @(negedge clk);
    @(negedge clk);
    enable = 1'b1;
    wait_rdy(t2, "reenable");
    chk("reen_rdy_gap", t2 - t, 5);
    for (int i = 0; i < 4; i++) chk($sformatf("en_gap_w%0d", i), w_hist[t + 1][i], 22);
    repeat (6) @(negedge clk);
    chk("reen_settle_len", last_set_len, 3 * FC);
    t = t2;
`endif

    repeat (10) @(negedge clk);
    chk("pre_rst_pwm", int'(pwm), 15);
    rst = 1'b0;
    #1;
    chk("mid_rst_pwm", int'(pwm), 0);
    chk("mid_rst_rdy", int'(rdy), 0);
    chk("mid_rst_settling", int'(settling), 0);
    chk("mid_rst_angle_err", int'(angle_err), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_frame_tick", int'(frame_tick), 1);
    @(posedge clk);
    base = ft_cnt;
    wait_rdy(t2, "post_rst");
    chk("post_rst_rdy_gap", t2 - base, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/servo_pwm_driver.md
Name: servo_pwm_driver

Overview:
- Consumer end of the four-joint angle bus. Takes angle1..angle4 (degrees, 0..180) and drives four 50 Hz hobby-servo PWM lines.
- Times joint settling and returns the rdy strobe that steps the move sequencer to its next move.
- Sits between the move sequencer and the arm servo header. rdy closes the sequencer's handshake loop.

Parameters:
- FRAME_CYCLES, 1000000: clk cycles per PWM frame (20 ms at 50 MHz).
- MIN_PULSE, 25000: high time for 0 degrees (0.5 ms).
- CYCLES_PER_DEG, 556: added high time per degree.
- MAX_ANGLE, 180: angle clamp limit.
- SETTLE_FRAMES, 25: frames waited after any channel changes target.
- SHORT_SETTLE_FRAMES, 1: frames waited when no target changed.
- RDY_WIDTH, 4: rdy high time in clk cycles.
- SLEW_DEG, 2: degrees per frame, used only with SLEW_LIMIT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- enable  in  1  1 = servos driven; 0 = PWM held low, handshake restarts
- angle1  in  8  bottom extension target, degrees
- angle2  in  8  bottom rotation target
- angle3  in  8  top extension target
- angle4  in  8  end rotation target
- pwm  out  4  servo pulses, bit0 = angle1 .. bit3 = angle4
- rdy  out  1  move-settled strobe, RDY_WIDTH cycles high
- settling  out  1  high while the settle countdown runs
- frame_tick  out  1  one-cycle pulse at each frame start
- angle_err  out  1  sticky; set when any latched input exceeds MAX_ANGLE

Behaviour:
- Reset (rst=0, async):
  - pwm=0, rdy=0, settling=0, frame_tick=0, angle_err=0.
  - frame_cnt=0, latched angles=0, previous angles=0, first=1, state=LATCH_WAIT.
- Frame counter:
  - Counts 0..FRAME_CYCLES-1 and wraps. Free-running regardless of enable.
  - Frame start (fs) = cycle with frame_cnt==0.
  - frame_tick is registered: high the cycle after fs.
- Width:
  - Each channel computes w_i = MIN_PULSE + a_i*CYCLES_PER_DEG, where a_i is the latched angle.
  - Intermediate width is at least clog2(FRAME_CYCLES)+1 bits; no truncation.
  - If MIN_PULSE+MAX_ANGLE*CYCLES_PER_DEG >= FRAME_CYCLES, that is an elaboration error.
- PWM:
  - pwm[i] is registered: pwm[i] <= enable && (frame_cnt < w_i). One-cycle latency.
  - Widths change only at fs, so there are no runt or partial pulses.
- Clamp: any input > MAX_ANGLE is latched as MAX_ANGLE and sets angle_err. angle_err clears only on reset.
- FSM:
  - LATCH_WAIT, on fs:
    - Latch all four clamped inputs.
    - changed = (latched != previous) or first.
    - settle_cnt = changed ? SETTLE_FRAMES : SHORT_SETTLE_FRAMES.
    - previous <= latched; first <= 0.
    - Go to SETTLING.
  - SETTLING (settling=1): on each later fs, settle_cnt decrements. When it reaches 0, go to RDY with rdy=1 from the next cycle.
  - RDY: rdy held high exactly RDY_WIDTH cycles, then rdy=0 and go to LATCH_WAIT.
  - The sequencer updates its angles on rdy's rising edge; those values are sampled at the next fs. Inputs are ignored outside LATCH_WAIT fs cycles.
- Timing:
  - A changed move yields rdy SETTLE_FRAMES frames after its latch.
  - An unchanged move yields rdy SHORT_SETTLE_FRAMES frames after its latch.
  - rdy is always eventually produced, so a move that leaves all angles unchanged never stalls the sequencer.
- enable=0:
  - pwm forced 0 next cycle; rdy and settling forced 0.
  - State goes to LATCH_WAIT with first=1.
  - On re-enable, the full SETTLE_FRAMES wait applies.
- enable falling mid-RDY truncates the rdy pulse.
- fs coinciding with the RDY state: ignored; latching waits for the next fs after RDY ends.
- Reset mid-frame: everything returns to reset values immediately; the frame restarts at 0 after release.

Optional Feature:
- Macro SLEW_LIMIT_EN.
- Defined:
  - Each channel keeps a commanded angle c_i.
  - At each fs, c_i moves toward its latched target by min(SLEW_DEG, |target-c_i|), and w_i uses c_i.
  - In SETTLING, settle_cnt does not decrement until all c_i equal their targets.
  - After reset, c_i = 0.
- Undefined: c_i equals the latched target immediately; no slew logic is present.

Test Plan:
All cases use FRAME_CYCLES=1000, MIN_PULSE=25, CYCLES_PER_DEG=5, SETTLE_FRAMES=3, SHORT_SETTLE_FRAMES=1, RDY_WIDTH=4, enable=1.
- Reset release, angles all 0:
  - Every pwm bit is high 25 cycles per frame.
  - First rdy rises one cycle after the 4th fs (first-latch fs + 3) and is high exactly 4 cycles.
- After rdy, angle2 set to 38 and others unchanged:
  - From the next fs, pwm[1] is high 215 cycles per frame.
  - Next rdy comes 3 frames after that latch.
- After rdy, all inputs unchanged:
  - rdy comes 1 frame after the latch; settling is high for exactly 1 frame.
- angle4=200:
  - pwm[3] high 925 cycles (180 degrees); angle_err=1 and stays 1 until reset.
- enable dropped to 0 mid-SETTLING for 3 cycles:
  - pwm=0 from the next cycle; no rdy.
  - After re-enable, rdy comes 3 frames after the next latch.
- SLEW_LIMIT_EN with SLEW_DEG=2, angle1 0->10:
  - pwm[0] width steps 35, 45, 55, 65, 75 over 5 frames.
  - rdy comes 3 frames after width reaches 75.
